// File: rtl/tile_flip_pkg.sv
// -----------------------------------------------------------------------------
// tile_flip_pkg
// Shared types and helpers for the tile-flip game controller.
//   - state_e        : session FSM states (home / load / play / win)
//   - calc_lvl_w()   : width of the level register, never below 1 bit
//   - calc_idx_w()   : width of a tile index, never below 1 bit
//   - DEF_*          : default grid geometry and counter width
// -----------------------------------------------------------------------------
package tile_flip_pkg;

  localparam int DEF_ROWS       = 4;
  localparam int DEF_COLS       = 4;
  localparam int DEF_NUM_LEVELS = 4;
  localparam int DEF_MOVE_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    WON  = 2'd3
  } state_e;

  // A single level (or a single tile) still needs one bit to carry its index.
  function automatic int calc_lvl_w(input int numLevels);
    return (numLevels <= 1) ? 1 : $clog2(numLevels);
  endfunction

  function automatic int calc_idx_w(input int numTiles);
    return (numTiles <= 1) ? 1 : $clog2(numTiles);
  endfunction

endpackage

// File: rtl/flip_mask_gen.sv
// -----------------------------------------------------------------------------
// flip_mask_gen
// Purely combinational "lights-out" neighbour mask for a ROWS x COLS grid.
// Tile index is row*COLS + col. The mask holds the selected tile plus its
// orthogonal neighbours; nothing wraps across rows or grid edges.
// Ports:
//   idx_i  : tile index to flip
//   mask_o : one bit per tile, 1 = this tile toggles
// An index outside the grid yields an all-zero mask.
// -----------------------------------------------------------------------------
module flip_mask_gen
  import tile_flip_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  localparam int NUM_TILES = ROWS * COLS,
  localparam int IDX_W     = calc_idx_w(NUM_TILES)
) (
  input  logic [IDX_W-1:0]     idx_i,
  output logic [NUM_TILES-1:0] mask_o
);

  // Built tile by tile: tile t toggles when idx is t itself or one of t's
  // in-grid neighbours. Neighbourhood is symmetric, so this equals the mask
  // "around idx", but the row/column of every t is a constant here and no
  // divider on idx is needed. The row/column guards stop edge wrap-around,
  // and an out-of-range idx never matches any in-grid tile.
  always_comb begin
    mask_o = '0;
    for (int t = 0; t < NUM_TILES; t++) begin
      mask_o[t] = (int'(idx_i) == t)
               || (((t / COLS) > 0)        && (int'(idx_i) == t - COLS))
               || (((t / COLS) < ROWS - 1) && (int'(idx_i) == t + COLS))
               || (((t % COLS) > 0)        && (int'(idx_i) == t - 1))
               || (((t % COLS) < COLS - 1) && (int'(idx_i) == t + 1));
    end
  end

endmodule

// File: rtl/tile_flip_ctrl.sv
// -----------------------------------------------------------------------------
// tile_flip_ctrl
// Game-session controller for the tile-flip game on a ROWS x COLS grid.
// Runs the home/load/play/win session FSM, applies lights-out flips and keeps
// a saturating move counter. Every output comes from a register or from the
// registered state, so no input reaches an output combinationally.
// Ports:
//   clk_i           : system clock
//   reset_ni        : asynchronous active-low reset
//   level_req_i     : debounced level-select pulses, one bit per level
//   abort_i         : return to the home screen
//   level_pattern_i : start pattern of the level currently on level_o
//   flip_valid_i    : flip request
//   flip_idx_i      : tile to flip (row*COLS + col)
//   flip_ready_o    : flip accepted when flip_valid_i && flip_ready_o
//   tiles_o         : current tile states, 1 = lit
//   level_o         : selected level
//   playing_o       : high in PLAY
//   won_o           : high in WON
//   move_count_o    : accepted flips this session, saturating
// -----------------------------------------------------------------------------
module tile_flip_ctrl
  import tile_flip_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int MOVE_W     = DEF_MOVE_W,
  localparam int NUM_TILES = ROWS * COLS,
  localparam int LVL_W     = calc_lvl_w(NUM_LEVELS),
  localparam int IDX_W     = calc_idx_w(NUM_TILES)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [NUM_LEVELS-1:0] level_req_i,
  input  logic                  abort_i,
  input  logic [NUM_TILES-1:0]  level_pattern_i,
  input  logic                  flip_valid_i,
  input  logic [IDX_W-1:0]      flip_idx_i,
  output logic                  flip_ready_o,
  output logic [NUM_TILES-1:0]  tiles_o,
  output logic [LVL_W-1:0]      level_o,
  output logic                  playing_o,
  output logic                  won_o,
  output logic [MOVE_W-1:0]     move_count_o
);

  state_e               state_q, state_d;
  logic [NUM_TILES-1:0] tiles_q, tiles_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [MOVE_W-1:0]    move_q, move_d;

  logic [NUM_TILES-1:0] flipMask;
  logic [LVL_W-1:0]     reqIdx;
  logic                 idxInGrid;

  flip_mask_gen #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_mask (
    .idx_i  (flip_idx_i),
    .mask_o (flipMask)
  );

  // Lowest set level_req bit wins when several buttons are pressed at once:
  // scanning from the top down lets the lowest index overwrite the others.
  always_comb begin
    reqIdx = '0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (level_req_i[i]) begin
        reqIdx = LVL_W'(i);
      end
    end
  end

  // Indices past the last tile still complete the handshake but change
  // nothing; only meaningful when NUM_TILES is not a power of two.
  always_comb begin
    idxInGrid = int'(flip_idx_i) < NUM_TILES;
  end

  // Session FSM and datapath next-state. abort overrides everything else in
  // the same cycle and deliberately keeps tiles, level and move count so the
  // last score stays on screen. The win check looks at the registered tiles,
  // so a flip arriving in the cycle the board is already clear is still
  // applied while the FSM moves to WON.
  always_comb begin
    state_d = state_q;
    tiles_d = tiles_q;
    level_d = level_q;
    move_d  = move_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, WON: begin
          if (|level_req_i) begin
            level_d = reqIdx;
            state_d = LOAD;
          end
        end
        LOAD: begin
          tiles_d = level_pattern_i;
          move_d  = '0;
          state_d = PLAY;
        end
        PLAY: begin
          if (tiles_q == '0) begin
            state_d = WON;
          end
          if (flip_valid_i && idxInGrid) begin
            tiles_d = tiles_q ^ flipMask;
            move_d  = (move_q == '1) ? move_q : move_q + MOVE_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      tiles_q <= '0;
      level_q <= '0;
      move_q  <= '0;
    end else begin
      state_q <= state_d;
      tiles_q <= tiles_d;
      level_q <= level_d;
      move_q  <= move_d;
    end
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    flip_ready_o = (state_q == PLAY);
    playing_o    = (state_q == PLAY);
    won_o        = (state_q == WON);
    tiles_o      = tiles_q;
    level_o      = level_q;
    move_count_o = move_q;
  end

endmodule

// File: tb/tb_tile_flip_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tile_flip_ctrl
// Scoreboard bench for tile_flip_ctrl. Two instances: the default 4x4 grid
// with an 8-bit counter, and a 3x3 grid with a 2-bit counter so that both
// counter saturation and out-of-grid indices are reachable.
// Observations are packed as {tiles[15:0], moves[7:0], level[1:0],
// playing, won, ready}.
// -----------------------------------------------------------------------------
module tb_tile_flip_ctrl;

  typedef struct {
    string       tag;
    logic [28:0] vec;
  } exp_t;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_PLAY = 2;
  localparam int M_WON  = 3;

  logic clk = 1'b0;
  logic rstN;

  // Main 4x4 instance
  logic [3:0]  levelReq;
  logic        abort;
  logic [15:0] levelPattern;
  logic        flipValid;
  logic [3:0]  flipIdx;
  logic        flipReady;
  logic [15:0] tiles;
  logic [1:0]  level;
  logic        playing;
  logic        won;
  logic [7:0]  moveCount;

  // Small 3x3 instance with a 2-bit counter
  logic [3:0]  levelReqS;
  logic        abortS;
  logic [8:0]  levelPatternS;
  logic        flipValidS;
  logic [3:0]  flipIdxS;
  logic        flipReadyS;
  logic [8:0]  tilesS;
  logic [1:0]  levelS;
  logic        playingS;
  logic        wonS;
  logic [1:0]  moveCountS;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Golden model state for the main instance
  int          mState;
  logic [15:0] mTiles;
  logic [7:0]  mMoves;
  logic [1:0]  mLevel;

  logic [15:0] lvlTable [4];

  tile_flip_ctrl dut (
    .clk_i           (clk),
    .reset_ni        (rstN),
    .level_req_i     (levelReq),
    .abort_i         (abort),
    .level_pattern_i (levelPattern),
    .flip_valid_i    (flipValid),
    .flip_idx_i      (flipIdx),
    .flip_ready_o    (flipReady),
    .tiles_o         (tiles),
    .level_o         (level),
    .playing_o       (playing),
    .won_o           (won),
    .move_count_o    (moveCount)
  );

  tile_flip_ctrl #(
    .ROWS       (3),
    .COLS       (3),
    .NUM_LEVELS (4),
    .MOVE_W     (2)
  ) dutSat (
    .clk_i           (clk),
    .reset_ni        (rstN),
    .level_req_i     (levelReqS),
    .abort_i         (abortS),
    .level_pattern_i (levelPatternS),
    .flip_valid_i    (flipValidS),
    .flip_idx_i      (flipIdxS),
    .flip_ready_o    (flipReadyS),
    .tiles_o         (tilesS),
    .level_o         (levelS),
    .playing_o       (playingS),
    .won_o           (wonS),
    .move_count_o    (moveCountS)
  );

  always #5 clk = ~clk;

  // External level table, indexed by whatever level the controller selected
  initial begin
    lvlTable[0] = 16'h0000;
    lvlTable[1] = 16'h0272;
    lvlTable[2] = 16'h0000;
    lvlTable[3] = 16'h8001;
  end

  always_comb levelPattern = lvlTable[level];
  assign levelPatternS = 9'h1FF;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [28:0] pk(input logic [15:0] t, input logic [7:0] m,
                                     input logic [1:0] l, input logic p,
                                     input logic w, input logic r);
    return {t, m, l, p, w, r};
  endfunction

  function automatic logic [28:0] obsMain();
    return {tiles, moveCount, level, playing, won, flipReady};
  endfunction

  function automatic logic [28:0] obsSat();
    return {7'b0, tilesS, 6'b0, moveCountS, levelS, playingS, wonS, flipReadyS};
  endfunction

  function automatic string fmt(input logic [28:0] v);
    return $sformatf("tiles=%h moves=%0d level=%0d play/won/ready=%b%b%b",
                     v[28:13], v[12:5], v[4:3], v[2], v[1], v[0]);
  endfunction

  // Independent neighbour mask for a 4x4 grid, from row/column arithmetic
  function automatic logic [15:0] modelMask(input int idx);
    logic [15:0] m;
    int r, c;
    r = idx / 4;
    c = idx % 4;
    m = 16'h0;
    m[idx] = 1'b1;
    if (r > 0) m[idx-4] = 1'b1;
    if (r < 3) m[idx+4] = 1'b1;
    if (c > 0) m[idx-1] = 1'b1;
    if (c < 3) m[idx+1] = 1'b1;
    return m;
  endfunction

  function automatic logic [28:0] modelExp();
    return pk(mTiles, mMoves, mLevel, mState == M_PLAY, mState == M_WON, mState == M_PLAY);
  endfunction

  // One clock of the golden model for the main instance
  task automatic modelStep(input logic [3:0] lr, input logic fv, input logic [3:0] fi,
                           input logic ab);
    logic win;
    if (ab) begin
      mState = M_IDLE;
    end else begin
      case (mState)
        M_IDLE, M_WON: begin
          if (lr != 4'b0) begin
            for (int i = 3; i >= 0; i--) if (lr[i]) mLevel = 2'(i);
            mState = M_LOAD;
          end
        end
        M_LOAD: begin
          mTiles = lvlTable[mLevel];
          mMoves = 8'd0;
          mState = M_PLAY;
        end
        default: begin
          win = (mTiles == 16'h0);
          if (fv) begin
            mTiles = mTiles ^ modelMask(int'(fi));
            if (mMoves != 8'hFF) mMoves = mMoves + 8'd1;
          end
          mState = win ? M_WON : M_PLAY;
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input logic [3:0] lr, input logic fv, input logic [3:0] fi,
                               input logic ab);
    levelReq  = lr;
    flipValid = fv;
    flipIdx   = fi;
    abort     = ab;
  endtask

  task automatic applyStimulusS(input logic [3:0] lr, input logic fv, input logic [3:0] fi);
    levelReqS  = lr;
    flipValidS = fv;
    flipIdxS   = fi;
    abortS     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [28:0] got;
    applyStimulus(4'b0, 1'b0, 4'd0, 1'b0);
    applyStimulusS(4'b0, 1'b0, 4'd0);
    rstN = 1'b0;
    #3;
    sbq.push_back('{"reset main", pk(16'h0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
    e = sbq.pop_front();
    got = obsMain();
    vectors++;
    if (got !== e.vec) begin
      miscompares++;
      $display("[TB] FAIL %s: got %s, expected %s", e.tag, fmt(got), fmt(e.vec));
    end
    sbq.push_back('{"reset sat", pk(16'h0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
    e = sbq.pop_front();
    got = obsSat();
    vectors++;
    if (got !== e.vec) begin
      miscompares++;
      $display("[TB] FAIL %s: got %s, expected %s", e.tag, fmt(got), fmt(e.vec));
    end
    #4 rstN = 1'b1;
    // A flip offered in IDLE must be ignored
    applyStimulus(4'b0, 1'b1, 4'd5, 1'b0);
    sbq.push_back('{"idle ignores flip", pk(16'h0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
    tick();
    e = sbq.pop_front();
    got = obsMain();
    vectors++;
    if (got !== e.vec) begin
      miscompares++;
      $display("[TB] FAIL %s: got %s, expected %s", e.tag, fmt(got), fmt(e.vec));
    end
    applyStimulus(4'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_load();
    exp_t e;
    logic [28:0] got;
    logic [3:0]  lr [2];
    logic [28:0] ex [2];
    lr[0] = 4'b0110; ex[0] = pk(16'h0000, 8'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    lr[1] = 4'b0000; ex[1] = pk(16'h0272, 8'd0, 2'd1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(lr[i], 1'b0, 4'd0, 1'b0);
      sbq.push_back('{$sformatf("load step %0d", i), ex[i]});
      tick();
      e = sbq.pop_front();
      got = obsMain();
      vectors++;
      if (got !== e.vec) begin
        miscompares++;
        $display("[TB] FAIL %s: got %s, expected %s", e.tag, fmt(got), fmt(e.vec));
      end
    end
  endtask

  task automatic test_center_flip();
    exp_t e;
    logic [28:0] got;
    logic        fv [3];
    logic [3:0]  fi [3];
    logic [28:0] ex [3];
    fv[0] = 1'b1; fi[0] = 4'd5; ex[0] = pk(16'h0000, 8'd1, 2'd1, 1'b1, 1'b0, 1'b1);
    fv[1] = 1'b0; fi[1] = 4'd0; ex[1] = pk(16'h0000, 8'd1, 2'd1, 1'b0, 1'b1, 1'b0);
    fv[2] = 1'b1; fi[2] = 4'd0; ex[2] = pk(16'h0000, 8'd1, 2'd1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0, fv[i], fi[i], 1'b0);
      sbq.push_back('{$sformatf("centre flip step %0d", i), ex[i]});
      tick();
      e = sbq.pop_front();
      got = obsMain();
      vectors++;
      if (got !== e.vec) begin
        miscompares++;
        $display("[TB] FAIL %s: got %s, expected %s", e.tag, fmt(got), fmt(e.vec));
      end
    end
    applyStimulus(4'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // Level 2 is all-dark: the flip offered on the first PLAY cycle is applied
  // while the FSM moves to WON, so each round shows one mask from tiles=0.
  task automatic test_edge_masks();
    exp_t e;
    logic [28:0] got;
    logic [3:0]  idx  [4];
    logic [15:0] mask [4];
    logic [15:0] prevT;
    logic [7:0]  prevM;
    logic [3:0]  lr;
    logic        fv;
    logic [28:0] ex;
    idx[0] = 4'd0;  mask[0] = 16'h0013;
    idx[1] = 4'd3;  mask[1] = 16'h008C;
    idx[2] = 4'd4;  mask[2] = 16'h0131;
    idx[3] = 4'd15; mask[3] = 16'hC800;
    prevT = 16'h0000;
    prevM = 8'd1;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        lr = (s == 0) ? 4'b0100 : 4'b0000;
        fv = (s == 2);
        case (s)
          0:       ex = pk(prevT, prevM, 2'd2, 1'b0, 1'b0, 1'b0);
          1:       ex = pk(16'h0000, 8'd0, 2'd2, 1'b1, 1'b0, 1'b1);
          default: ex = pk(mask[k], 8'd1, 2'd2, 1'b0, 1'b1, 1'b0);
        endcase
        applyStimulus(lr, fv, idx[k], 1'b0);
        sbq.push_back('{$sformatf("edge mask idx %0d step %0d", idx[k], s), ex});
        tick();
        e = sbq.pop_front();
        got = obsMain();
        vectors++;
        if (got !== e.vec) begin
          miscompares++;
          $display("[TB] FAIL %s: got %s, expected %s", e.tag, fmt(got), fmt(e.vec));
        end
      end
      prevT = mask[k];
      prevM = 8'd1;
    end
    applyStimulus(4'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_abort();
    exp_t e;
    logic [28:0] got;
    logic [3:0]  lr [5];
    logic        fv [5];
    logic [3:0]  fi [5];
    logic        ab [5];
    logic [28:0] ex [5];
    lr[0] = 4'b0010; fv[0] = 1'b0; fi[0] = 4'd0; ab[0] = 1'b0;
    ex[0] = pk(16'hC800, 8'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    lr[1] = 4'b0000; fv[1] = 1'b0; fi[1] = 4'd0; ab[1] = 1'b0;
    ex[1] = pk(16'h0272, 8'd0, 2'd1, 1'b1, 1'b0, 1'b1);
    lr[2] = 4'b0000; fv[2] = 1'b1; fi[2] = 4'd0; ab[2] = 1'b0;
    ex[2] = pk(16'h0261, 8'd1, 2'd1, 1'b1, 1'b0, 1'b1);
    lr[3] = 4'b0001; fv[3] = 1'b1; fi[3] = 4'd5; ab[3] = 1'b1;
    ex[3] = pk(16'h0261, 8'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    lr[4] = 4'b0000; fv[4] = 1'b0; fi[4] = 4'd0; ab[4] = 1'b0;
    ex[4] = pk(16'h0261, 8'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(lr[i], fv[i], fi[i], ab[i]);
      sbq.push_back('{$sformatf("abort step %0d", i), ex[i]});
      tick();
      e = sbq.pop_front();
      got = obsMain();
      vectors++;
      if (got !== e.vec) begin
        miscompares++;
        $display("[TB] FAIL %s: got %s, expected %s", e.tag, fmt(got), fmt(e.vec));
      end
    end
  endtask

  // Continuous random flips checked against the golden model
  task automatic test_back_to_back();
    exp_t e;
    logic [28:0] got;
    logic [3:0]  lr;
    logic        fv;
    logic [3:0]  fi;
    mState = M_IDLE;
    mTiles = 16'h0261;
    mMoves = 8'd1;
    mLevel = 2'd1;
    for (int i = 0; i < 26; i++) begin
      lr = (i == 0) ? 4'b1000 : 4'b0000;
      fv = (i >= 2) && ($urandom_range(0, 3) != 0);
      fi = 4'($urandom_range(0, 15));
      applyStimulus(lr, fv, fi, 1'b0);
      modelStep(lr, fv, fi, 1'b0);
      sbq.push_back('{$sformatf("back-to-back cycle %0d", i), modelExp()});
      tick();
      e = sbq.pop_front();
      got = obsMain();
      vectors++;
      if (got !== e.vec) begin
        miscompares++;
        $display("[TB] FAIL %s: got %s, expected %s", e.tag, fmt(got), fmt(e.vec));
      end
    end
    applyStimulus(4'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_reset_midplay();
    exp_t e;
    logic [28:0] got;
    logic [3:0]  lr [3];
    logic        ab [3];
    lr[0] = 4'b0000; ab[0] = 1'b1;
    lr[1] = 4'b0010; ab[1] = 1'b0;
    lr[2] = 4'b0000; ab[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(lr[i], 1'b0, 4'd0, ab[i]);
      modelStep(lr[i], 1'b0, 4'd0, ab[i]);
      sbq.push_back('{$sformatf("midplay setup %0d", i), modelExp()});
      tick();
      e = sbq.pop_front();
      got = obsMain();
      vectors++;
      if (got !== e.vec) begin
        miscompares++;
        $display("[TB] FAIL %s: got %s, expected %s", e.tag, fmt(got), fmt(e.vec));
      end
    end
    // Reset lands between clock edges and must act immediately
    #2 rstN = 1'b0;
    #1;
    sbq.push_back('{"async reset in PLAY", pk(16'h0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
    e = sbq.pop_front();
    got = obsMain();
    vectors++;
    if (got !== e.vec) begin
      miscompares++;
      $display("[TB] FAIL %s: got %s, expected %s", e.tag, fmt(got), fmt(e.vec));
    end
    applyStimulus(4'b0, 1'b1, 4'd5, 1'b0);
    #2 rstN = 1'b1;
    sbq.push_back('{"flip after reset", pk(16'h0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
    tick();
    e = sbq.pop_front();
    got = obsMain();
    vectors++;
    if (got !== e.vec) begin
      miscompares++;
      $display("[TB] FAIL %s: got %s, expected %s", e.tag, fmt(got), fmt(e.vec));
    end
    applyStimulus(4'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // 3x3 grid, 2-bit counter: saturation, out-of-grid indices, 3x3 masks
  task automatic test_saturation();
    exp_t e;
    logic [28:0] got;
    logic [3:0]  lr [11];
    logic        fv [11];
    logic [3:0]  fi [11];
    logic [15:0] et [11];
    logic [7:0]  em [11];
    for (int i = 0; i < 11; i++) begin
      lr[i] = 4'b0;
      fv[i] = (i >= 2);
      fi[i] = 4'd0;
    end
    lr[0] = 4'b0001;
    fi[7] = 4'd9;
    fi[8] = 4'd15;
    fi[9] = 4'd4;
    fi[10] = 4'd8;
    et[0] = 16'h000; em[0] = 8'd0;
    et[1] = 16'h1FF; em[1] = 8'd0;
    et[2] = 16'h1F4; em[2] = 8'd1;
    et[3] = 16'h1FF; em[3] = 8'd2;
    et[4] = 16'h1F4; em[4] = 8'd3;
    et[5] = 16'h1FF; em[5] = 8'd3;
    et[6] = 16'h1F4; em[6] = 8'd3;
    et[7] = 16'h1F4; em[7] = 8'd3;
    et[8] = 16'h1F4; em[8] = 8'd3;
    et[9] = 16'h14E; em[9] = 8'd3;
    et[10] = 16'h0EE; em[10] = 8'd3;
    for (int i = 0; i < 11; i++) begin
      applyStimulusS(lr[i], fv[i], fi[i]);
      sbq.push_back('{$sformatf("saturation step %0d idx %0d", i, fi[i]),
                      pk(et[i], em[i], 2'd0, i >= 1, 1'b0, i >= 1)});
      tick();
      e = sbq.pop_front();
      got = obsSat();
      vectors++;
      if (got !== e.vec) begin
        miscompares++;
        $display("[TB] FAIL %s: got %s, expected %s", e.tag, fmt(got), fmt(e.vec));
      end
    end
    applyStimulusS(4'b0, 1'b0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_center_flip();
    test_edge_masks();
    test_abort();
    test_back_to_back();
    test_reset_midplay();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
